sdram_req_queue: RTL and testbench

- Request buffer upstream of `memory_controller`; drives its user port (`ADR_IN`, `BDR_IN`, `DIN`, `RE_IN`, `WE_IN`) and reads back `DOUT` and `RDY`.
- Accepts read/write requests from a host over a valid/ready handshake and buffers them in order in a DEPTH-entry FIFO.
- Issues buffered requests to the controller one at a time and returns read data on a one-cycle strobe.

---
 rtl/sdram_req_queue.sv | 207 ++++++++++++++++++++
 tb/tb_sdram_req_queue.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_req_queue.sv
// rtl/sdram_req_queue.sv - in-order request FIFO and single-issue command front end for memory_controller
// Optional statistics counters (CNT_CLR, WR_CNT, RD_CNT) are built when SDRAM_REQ_QUEUE_STATS_EN is defined.
module sdram_req_queue #(
   parameter int DEPTH  = 8,
   parameter int ADR_W  = 13,
   parameter int DATA_W = 16
) (
   input  logic                   CLK,
   input  logic                   NRST,
   // host request side
   input  logic                   REQ_VALID,
   output logic                   REQ_READY,
   input  logic                   REQ_WE,
   input  logic [ADR_W-1:0]       REQ_ADR,
   input  logic [1:0]             REQ_BDR,
   input  logic [DATA_W-1:0]      REQ_DATA,
   // host read return
   output logic                   RD_VALID,
   output logic [DATA_W-1:0]      RD_DATA,
   // queue status
   output logic                   FULL,
   output logic                   EMPTY,
   output logic [$clog2(DEPTH):0] LEVEL,
   // controller user port
   output logic [ADR_W-1:0]       ADR_IN,
   output logic [1:0]             BDR_IN,
   output logic [DATA_W-1:0]      DIN,
   output logic                   RE_IN,
   output logic                   WE_IN,
   input  logic [DATA_W-1:0]      DOUT,
   input  logic                   RDY
`ifdef SDRAM_REQ_QUEUE_STATS_EN
   ,
   input  logic                   CNT_CLR,
   output logic [15:0]            WR_CNT,
   output logic [15:0]            RD_CNT
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int ENT_W = 1 + 2 + ADR_W + DATA_W;
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

   // Issue FSM encoding
   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_ISSUE     = 2'd1;
   localparam logic [1:0] S_WAIT_ACK  = 2'd2;
   localparam logic [1:0] S_WAIT_DONE = 2'd3;

   logic [ENT_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;
   logic [1:0]        state;
   logic              cmd_we;

   logic              push;
   logic              pop;
   logic [ENT_W-1:0]  head;
   logic              head_we;
   logic [1:0]        head_bdr;
   logic [ADR_W-1:0]  head_adr;
   logic [DATA_W-1:0] head_data;

   // Status comes from the registered count only, so a same-cycle pop never frees a slot early.
   assign FULL      = (count == CNT_FULL);
   assign EMPTY     = (count == '0);
   assign LEVEL     = count;
   assign REQ_READY = !FULL;

   assign push = REQ_VALID && REQ_READY;
   assign pop  = (state == S_IDLE) && !EMPTY && RDY;

   // Head-of-queue entry layout: {WE, BDR, ADR, DATA}
   assign head      = mem[rd_ptr];
   assign head_we   = head[ENT_W-1];
   assign head_bdr  = head[ENT_W-2 -: 2];
   assign head_adr  = head[DATA_W +: ADR_W];
   assign head_data = head[DATA_W-1:0];

   // Entry storage: written on every accepted push, no reset needed since count gates reads.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr] <= {REQ_WE, REQ_BDR, REQ_ADR, REQ_DATA};
      end
   end

   // Write and read pointers; natural power-of-two wrap.
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Occupancy count; simultaneous push and pop leaves it unchanged.
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         count <= '0;
      end else begin
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Issue FSM: one request in flight, handshake on RDY falling then rising.
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (pop) begin
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               state <= S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
               if (!RDY) begin
                  state <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (RDY) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Command field registers: loaded on pop and held until the next pop.
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         cmd_we <= 1'b0;
         ADR_IN <= '0;
         BDR_IN <= '0;
         DIN    <= '0;
      end else if (pop) begin
         cmd_we <= head_we;
         ADR_IN <= head_adr;
         BDR_IN <= head_bdr;
         DIN    <= head_data;
      end
   end

   // Command strobes: registered, high only for the ISSUE cycle, never both at once.
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         WE_IN <= 1'b0;
         RE_IN <= 1'b0;
      end else begin
         WE_IN <= pop && head_we;
         RE_IN <= pop && !head_we;
      end
   end

   // Read return: capture DOUT when RDY rises in WAIT_DONE and strobe RD_VALID the next cycle.
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         RD_VALID <= 1'b0;
         RD_DATA  <= '0;
      end else begin
         RD_VALID <= 1'b0;
         if ((state == S_WAIT_DONE) && RDY && !cmd_we) begin
            RD_DATA  <= DOUT;
            RD_VALID <= 1'b1;
         end
      end
   end

`ifdef SDRAM_REQ_QUEUE_STATS_EN
   // Statistics: count write strobes and read returns; clear wins over a same-cycle increment.
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         WR_CNT <= 16'd0;
         RD_CNT <= 16'd0;
      end else if (CNT_CLR) begin
         WR_CNT <= 16'd0;
         RD_CNT <= 16'd0;
      end else begin
         if (WE_IN) begin
            WR_CNT <= WR_CNT + 16'd1;
         end
         if (RD_VALID) begin
            RD_CNT <= RD_CNT + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_sdram_req_queue.sv
// tb/tb_sdram_req_queue.sv - self-checking bench for sdram_req_queue with a simple controller model
module tb_sdram_req_queue;

   logic        CLK;
   logic        NRST;
   logic        REQ_VALID;
   logic        REQ_READY;
   logic        REQ_WE;
   logic [12:0] REQ_ADR;
   logic [1:0]  REQ_BDR;
   logic [15:0] REQ_DATA;
   logic        RD_VALID;
   logic [15:0] RD_DATA;
   logic        FULL;
   logic        EMPTY;
   logic [3:0]  LEVEL;
   logic [12:0] ADR_IN;
   logic [1:0]  BDR_IN;
   logic [15:0] DIN;
   logic        RE_IN;
   logic        WE_IN;
   logic [15:0] DOUT;
   logic        RDY;
`ifdef SDRAM_REQ_QUEUE_STATS_EN
   logic        CNT_CLR;
   logic [15:0] WR_CNT;
   logic [15:0] RD_CNT;
`endif

   typedef struct {
      logic        we;
      logic [12:0] adr;
      logic [1:0]  bdr;
      logic [15:0] data;
      logic [15:0] exp_rd;
   } vec_t;

   typedef struct {
      logic        we;
      logic [12:0] adr;
      logic [1:0]  bdr;
      logic [15:0] din;
      int          cyc;
   } cmd_t;

   cmd_t        cmd_q[$];
   logic [15:0] rd_q[$];
   int          n_chk = 0;
   int          n_pass = 0;
   int          mon_cyc = 0;
   int          both_hi = 0;
   int          unstable = 0;
   bit          hold = 0;
   bit          ovr_en = 0;
   logic [15:0] ovr_val = 16'h0;
   int          busy_len = 3;

   sdram_req_queue #(.DEPTH(8), .ADR_W(13), .DATA_W(16)) dut (
      .CLK(CLK), .NRST(NRST),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
      .REQ_ADR(REQ_ADR), .REQ_BDR(REQ_BDR), .REQ_DATA(REQ_DATA),
      .RD_VALID(RD_VALID), .RD_DATA(RD_DATA),
      .FULL(FULL), .EMPTY(EMPTY), .LEVEL(LEVEL),
      .ADR_IN(ADR_IN), .BDR_IN(BDR_IN), .DIN(DIN), .RE_IN(RE_IN), .WE_IN(WE_IN),
      .DOUT(DOUT), .RDY(RDY)
`ifdef SDRAM_REQ_QUEUE_STATS_EN
      , .CNT_CLR(CNT_CLR), .WR_CNT(WR_CNT), .RD_CNT(RD_CNT)
`endif
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Read data the controller model returns: {0, bank, address}
   function automatic logic [15:0] rd_of(input logic [1:0] b, input logic [12:0] a);
      return {1'b0, b, a};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   // Controller model and output monitor, evaluated on the falling edge.
   initial begin : ctrl_model
      int          busy;
      logic        pend_rd;
      logic [12:0] la;
      logic [1:0]  lb;
      logic [12:0] ref_adr;
      logic [1:0]  ref_bdr;
      logic [15:0] ref_din;
      busy = 0; pend_rd = 0; la = 0; lb = 0;
      ref_adr = 0; ref_bdr = 0; ref_din = 0;
      RDY = 1'b1;
      DOUT = 16'h0;
      forever begin
         @(negedge CLK);
         mon_cyc++;
         if (NRST) begin
            if (RE_IN && WE_IN) both_hi++;
            if (RE_IN || WE_IN) begin
               cmd_q.push_back('{WE_IN, ADR_IN, BDR_IN, DIN, mon_cyc});
               ref_adr = ADR_IN; ref_bdr = BDR_IN; ref_din = DIN;
            end else if (ADR_IN !== ref_adr || BDR_IN !== ref_bdr || DIN !== ref_din) begin
               unstable++;
            end
            if (RD_VALID) rd_q.push_back(RD_DATA);
         end else begin
            ref_adr = 0; ref_bdr = 0; ref_din = 0;
         end
         if (!NRST) begin
            busy = 0;
            RDY = 1'b1;
         end else if (!hold) begin
            if (busy > 0) begin
               busy--;
               if (busy == 0) begin
                  RDY = 1'b1;
                  if (pend_rd) DOUT = ovr_en ? ovr_val : rd_of(lb, la);
               end
            end else if (RE_IN || WE_IN) begin
               RDY = 1'b0;
               busy = busy_len;
               pend_rd = RE_IN;
               la = ADR_IN;
               lb = BDR_IN;
            end else begin
               RDY = 1'b1;
            end
         end
      end
   end

   task automatic push(input vec_t v, output bit acc);
      @(negedge CLK);
      REQ_VALID = 1'b1;
      REQ_WE    = v.we;
      REQ_ADR   = v.adr;
      REQ_BDR   = v.bdr;
      REQ_DATA  = v.data;
      acc = REQ_READY;
      @(posedge CLK);
      #1 REQ_VALID = 1'b0;
   endtask

   task automatic wait_logs(input int nc, input int nr, input string name);
      int t;
      t = 0;
      while ((cmd_q.size() < nc || rd_q.size() < nr) && t < 3000) begin
         @(negedge CLK);
         t++;
      end
      chk({name, "_done_in_time"}, (t < 3000) ? 32'd1 : 32'd0, 32'd1);
      repeat (8) @(negedge CLK);
   endtask

   initial begin
      vec_t fill [9];
      vec_t strm [20];
      vec_t v;
      bit   acc;
      int   n_acc;
      int   r;
      int   lvl_bad;
      int   miss;
      int   t;

      fill[0] = '{1'b1, 13'h0001, 2'd0, 16'h1111, 16'h0000};
      fill[1] = '{1'b0, 13'h0002, 2'd1, 16'h0000, 16'h2002};
      fill[2] = '{1'b1, 13'h1000, 2'd2, 16'h2222, 16'h0000};
      fill[3] = '{1'b0, 13'h0FF0, 2'd3, 16'h0000, 16'h6FF0};
      fill[4] = '{1'b1, 13'h00AB, 2'd1, 16'hCAFE, 16'h0000};
      fill[5] = '{1'b0, 13'h1ABC, 2'd0, 16'h0000, 16'h1ABC};
      fill[6] = '{1'b1, 13'h1FFF, 2'd3, 16'hFFFF, 16'h0000};
      fill[7] = '{1'b0, 13'h0000, 2'd2, 16'h0000, 16'h4000};
      fill[8] = '{1'b1, 13'h0777, 2'd0, 16'hDEAD, 16'h0000};
      for (int i = 0; i < 20; i++) begin
         strm[i].we     = i[0];
         strm[i].adr    = 13'(32'h0100 + i * 37);
         strm[i].bdr    = 2'(i);
         strm[i].data   = 16'hA000 + 16'(i);
         strm[i].exp_rd = rd_of(strm[i].bdr, strm[i].adr);
      end

      NRST = 1'b1; REQ_VALID = 1'b0; REQ_WE = 1'b0;
      REQ_ADR = '0; REQ_BDR = '0; REQ_DATA = '0;
`ifdef SDRAM_REQ_QUEUE_STATS_EN
      CNT_CLR = 1'b0;
`endif

      // Reset values, before any clock edge
      #1 NRST = 1'b0;
      #1;
      chk("rst_empty", EMPTY, 1);
      chk("rst_full", FULL, 0);
      chk("rst_level", LEVEL, 0);
      chk("rst_req_ready", REQ_READY, 1);
      chk("rst_re_in", RE_IN, 0);
      chk("rst_we_in", WE_IN, 0);
      chk("rst_adr_in", ADR_IN, 0);
      chk("rst_bdr_in", BDR_IN, 0);
      chk("rst_din", DIN, 0);
      chk("rst_rd_valid", RD_VALID, 0);
      chk("rst_rd_data", RD_DATA, 0);
      repeat (3) @(negedge CLK);
      NRST = 1'b1;
      repeat (2) @(negedge CLK);

      // Single write
      cmd_q.delete(); rd_q.delete();
      v = '{1'b1, 13'h00A5, 2'd2, 16'hBEEF, 16'h0000};
      push(v, acc);
      chk("wr_accepted", acc, 1);
      wait_logs(1, 0, "wr");
      chk("wr_cmd_count", cmd_q.size(), 1);
      if (cmd_q.size() > 0) begin
         chk("wr_is_write", cmd_q[0].we, 1);
         chk("wr_adr", cmd_q[0].adr, 13'h00A5);
         chk("wr_bdr", cmd_q[0].bdr, 2);
         chk("wr_din", cmd_q[0].din, 16'hBEEF);
      end
      chk("wr_no_rd_valid", rd_q.size(), 0);
      chk("wr_adr_held", ADR_IN, 13'h00A5);
      chk("wr_din_held", DIN, 16'hBEEF);

      // Read return
      cmd_q.delete(); rd_q.delete();
      ovr_en = 1; ovr_val = 16'h1234;
      v = '{1'b0, 13'h1FFF, 2'd3, 16'h5555, 16'h1234};
      push(v, acc);
      wait_logs(1, 1, "rd");
      chk("rd_cmd_count", cmd_q.size(), 1);
      if (cmd_q.size() > 0) begin
         chk("rd_is_read", cmd_q[0].we, 0);
         chk("rd_adr", cmd_q[0].adr, 13'h1FFF);
         chk("rd_bdr", cmd_q[0].bdr, 3);
      end
      chk("rd_valid_count", rd_q.size(), 1);
      if (rd_q.size() > 0) chk("rd_data", rd_q[0], 16'h1234);
      repeat (10) @(negedge CLK);
      chk("rd_data_holds", RD_DATA, 16'h1234);
      chk("rd_valid_once", rd_q.size(), 1);
      ovr_en = 0;

      // Fill and back-pressure
      cmd_q.delete(); rd_q.delete();
      @(negedge CLK);
      hold = 1; RDY = 1'b0;
      n_acc = 0;
      for (int i = 0; i < 9; i++) begin
         push(fill[i], acc);
         if (acc) n_acc++;
      end
      @(negedge CLK);
      chk("fill_accepted", n_acc, 8);
      chk("fill_full", FULL, 1);
      chk("fill_req_ready", REQ_READY, 0);
      chk("fill_level", LEVEL, 8);
      chk("fill_no_issue", cmd_q.size(), 0);
      hold = 0; RDY = 1'b1;
      wait_logs(8, 4, "fill");
      chk("fill_cmd_count", cmd_q.size(), 8);
      chk("fill_drained", EMPTY, 1);
      r = 0;
      for (int i = 0; i < 8; i++) begin
         if (i < cmd_q.size()) begin
            chk($sformatf("fill_we_%0d", i), cmd_q[i].we, fill[i].we);
            chk($sformatf("fill_adr_%0d", i), cmd_q[i].adr, fill[i].adr);
            chk($sformatf("fill_bdr_%0d", i), cmd_q[i].bdr, fill[i].bdr);
            if (fill[i].we) chk($sformatf("fill_din_%0d", i), cmd_q[i].din, fill[i].data);
            if (i > 0) chk($sformatf("fill_gap_%0d", i),
                           (cmd_q[i].cyc - cmd_q[i-1].cyc >= 4) ? 32'd1 : 32'd0, 32'd1);
         end
         if (!fill[i].we) begin
            if (r < rd_q.size()) chk($sformatf("fill_rd_%0d", i), rd_q[r], fill[i].exp_rd);
            r++;
         end
      end

      // Simultaneous push/pop at LEVEL=4 with pointer wrap
      cmd_q.delete(); rd_q.delete();
      @(negedge CLK);
      hold = 1; RDY = 1'b0;
      for (int i = 0; i < 4; i++) push(strm[i], acc);
      @(negedge CLK);
      chk("strm_prefill_level", LEVEL, 4);
      lvl_bad = 0; miss = 0;
      hold = 0; RDY = 1'b1;
      for (int i = 4; i < 20; i++) begin
         REQ_VALID = 1'b1;
         REQ_WE    = strm[i].we;
         REQ_ADR   = strm[i].adr;
         REQ_BDR   = strm[i].bdr;
         REQ_DATA  = strm[i].data;
         @(negedge CLK);
         REQ_VALID = 1'b0;
         if (!(RE_IN || WE_IN)) miss++;
         if (LEVEL != 4) lvl_bad++;
         repeat (4) begin
            @(negedge CLK);
            if (LEVEL != 4) lvl_bad++;
         end
      end
      chk("strm_level_steady", lvl_bad, 0);
      chk("strm_pop_aligned", miss, 0);
      wait_logs(20, 10, "strm");
      chk("strm_cmd_count", cmd_q.size(), 20);
      r = 0;
      for (int i = 0; i < 20; i++) begin
         if (i < cmd_q.size()) begin
            chk($sformatf("strm_we_%0d", i), cmd_q[i].we, strm[i].we);
            chk($sformatf("strm_adr_%0d", i), cmd_q[i].adr, strm[i].adr);
            if (strm[i].we) chk($sformatf("strm_din_%0d", i), cmd_q[i].din, strm[i].data);
         end
         if (!strm[i].we) begin
            if (r < rd_q.size()) chk($sformatf("strm_rd_%0d", i), rd_q[r], strm[i].exp_rd);
            r++;
         end
      end

      // Reset mid-transfer with 3 entries queued
      busy_len = 20;
      for (int i = 0; i < 4; i++) push(fill[i], acc);
      repeat (2) @(negedge CLK);
      chk("rst_mid_pre_level", LEVEL, 3);
      #2 NRST = 1'b0;
      #1;
      chk("rst_mid_empty", EMPTY, 1);
      chk("rst_mid_level", LEVEL, 0);
      chk("rst_mid_re_in", RE_IN, 0);
      chk("rst_mid_we_in", WE_IN, 0);
      chk("rst_mid_req_ready", REQ_READY, 1);
      chk("rst_mid_adr_in", ADR_IN, 0);
      @(negedge CLK);
      cmd_q.delete(); rd_q.delete();
      busy_len = 3;
      @(negedge CLK);
      NRST = 1'b1;
      repeat (30) @(negedge CLK);
      chk("rst_mid_no_stale_cmd", cmd_q.size(), 0);
      chk("rst_mid_no_rd_valid", rd_q.size(), 0);

`ifdef SDRAM_REQ_QUEUE_STATS_EN
      // Statistics counters and clear priority
      chk("stats_rst_wr", WR_CNT, 0);
      cmd_q.delete(); rd_q.delete();
      for (int i = 0; i < 8; i++) begin
         v = '{(i < 5), 13'(i + 16), 2'd1, 16'(i), 16'h0};
         push(v, acc);
      end
      wait_logs(8, 3, "stats");
      chk("stats_wr_cnt", WR_CNT, 5);
      chk("stats_rd_cnt", RD_CNT, 3);
      v = '{1'b1, 13'h0055, 2'd0, 16'h7777, 16'h0};
      push(v, acc);
      t = 0;
      while (!WE_IN && t < 50) begin
         @(negedge CLK);
         t++;
      end
      chk("stats_we_seen", WE_IN, 1);
      CNT_CLR = 1'b1;
      @(negedge CLK);
      CNT_CLR = 1'b0;
      wait_logs(9, 3, "stats_clr");
      chk("stats_clr_wr", WR_CNT, 0);
      chk("stats_clr_rd", RD_CNT, 0);
`endif

      chk("never_both_strobes", both_hi, 0);
      chk("cmd_fields_stable", unstable, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
